// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU.
// Covers instruction opcodes, sequencer step encodings and ALU operation codes.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int IR_W   = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // ALU opcodes are laid out contiguously from OP_ADD, so the offset is the ALU code.
  function automatic logic [1:0] alu_op_of(input logic [2:0] opcode);
    logic [2:0] diff;
    diff = opcode - OP_ADD;
    return diff[1:0];
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath: mux selects,
// register and ALU latch enables, and the run/din inputs.
interface control_unit_if #(
  parameter int DATA_W = 16
);
  logic              run;
  logic [DATA_W-1:0] din;
  logic              ir_in;
  logic [7:0]        r_in;
  logic [2:0]        r_out;
  logic              din_en;
  logic              gout;
  logic              a_in;
  logic              g_in;
  logic [1:0]        alu_op;
  logic              done;

  modport master (
    input  run, din,
    output ir_in, r_in, r_out, din_en, gout, a_in, g_in, alu_op, done
  );

  modport slave (
    output run, din,
    input  ir_in, r_in, r_out, din_en, gout, a_in, g_in, alu_op, done
  );
endinterface

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder with enable; shared by the sequencer and the register file.
module decoder_3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign y[gi] = en && (sel == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM: fetches a word into the IR in T0, then drives the
// bus mux, register-file and ALU strobes through T1..T3.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int IR_W   = cpu_pkg::IR_W
) (
  input  logic clk,
  input  logic rst,
  control_unit_if.master bus
);

  state_t          state_reg, state_next;
  logic [IR_W-1:0] ir_reg;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       wr_en;
  logic       ir_load;
  logic       unused_din;

  assign opcode     = ir_reg[8:6];
  assign rx         = ir_reg[5:3];
  assign ry         = ir_reg[2:0];
  assign unused_din = ^bus.din[DATA_W-1:IR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= T0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (ir_load) begin
        ir_reg <= bus.din[IR_W-1:0];
      end
    end
  end

  // Every strobe is gated by rst so the datapath sees a quiet bus during reset.
  always_comb begin
    state_next = T0;
    ir_load    = 1'b0;
    wr_en      = 1'b0;
    bus.ir_in  = 1'b0;
    bus.r_out  = 3'd0;
    bus.din_en = 1'b0;
    bus.gout   = 1'b0;
    bus.a_in   = 1'b0;
    bus.g_in   = 1'b0;
    bus.alu_op = 2'b00;
    bus.done   = 1'b0;
    if (!rst) begin
      case (state_reg)
        T0: begin
          bus.ir_in  = bus.run;
          ir_load    = bus.run;
          state_next = bus.run ? T1 : T0;
        end
        T1: begin
          case (opcode)
            OP_MV: begin
              bus.r_out = ry;
              wr_en     = 1'b1;
              bus.done  = 1'b1;
            end
            OP_MVI: begin
              bus.din_en = 1'b1;
              wr_en      = 1'b1;
              bus.done   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              bus.r_out  = rx;
              bus.a_in   = 1'b1;
              state_next = T2;
            end
            default: begin
              bus.done = 1'b1;
            end
          endcase
        end
        T2: begin
          bus.r_out  = ry;
          bus.g_in   = 1'b1;
          bus.alu_op = alu_op_of(opcode);
          state_next = T3;
        end
        T3: begin
          bus.gout = 1'b1;
          wr_en    = 1'b1;
          bus.done = 1'b1;
        end
        default: begin
          state_next = T0;
        end
      endcase
    end
  end

  decoder_3to8 u_dec (
    .sel (rx),
    .en  (wr_en),
    .y   (bus.r_in)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: per-cycle output snapshots against
// hand-computed vectors, plus per-cycle mux-exclusivity and one-hot checks.
module tb_control_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  control_unit_if #(.DATA_W(16)) bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Packed view: {ir_in, r_in[7:0], r_out[2:0], din_en, gout, a_in, g_in, alu_op[1:0], done}
  function automatic logic [31:0] pk(input logic ir_in, input logic [7:0] r_in,
                                     input logic [2:0] r_out, input logic din_en,
                                     input logic gout, input logic a_in, input logic g_in,
                                     input logic [1:0] alu_op, input logic done);
    return {13'd0, ir_in, r_in, r_out, din_en, gout, a_in, g_in, alu_op, done};
  endfunction

  function automatic logic [31:0] snap();
    return {13'd0, bus.ir_in, bus.r_in, bus.r_out, bus.din_en, bus.gout,
            bus.a_in, bus.g_in, bus.alu_op, bus.done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] want);
    #1;
    chk(tag, snap(), want);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("excl", 32'(bus.din_en & bus.gout), 32'd0);
      chk("onehot0", 32'($onehot0(bus.r_in)), 32'd1);
    end
  end

  localparam logic [31:0] ZERO = 32'd0;

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.run = 1'b1;
    bus.din = 16'h0050;
    #2;
    chk("rst_outputs", snap(), ZERO);
    tick();
    chk("rst_hold", snap(), ZERO);
    bus.run = 1'b0;
    rst     = 1'b0;
    look("idle", ZERO);

    // mvi r2, 0x1234
    bus.run = 1'b1; bus.din = 16'h0050;
    look("mvi_t0", pk(1, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0));
    tick();
    bus.run = 1'b0; bus.din = 16'h1234;
    look("mvi_t1", pk(0, 8'h04, 0, 1, 0, 0, 0, 2'b00, 1));
    tick();
    look("mvi_back_t0", ZERO);

    // mv r5, r2
    bus.run = 1'b1; bus.din = 16'h002A;
    tick();
    bus.run = 1'b0;
    look("mv_t1", pk(0, 8'h20, 3'd2, 0, 0, 0, 0, 2'b00, 1));
    tick();

    // mv r5, r2 with junk in din[15:9]
    bus.run = 1'b1; bus.din = 16'hFE2A;
    tick();
    bus.run = 1'b0;
    look("mv_hi_t1", pk(0, 8'h20, 3'd2, 0, 0, 0, 0, 2'b00, 1));
    tick();

    // sub r1, r6
    bus.run = 1'b1; bus.din = 16'h00CE;
    tick();
    bus.run = 1'b0;
    look("sub_t1", pk(0, 8'h00, 3'd1, 0, 0, 1, 0, 2'b00, 0));
    tick();
    look("sub_t2", pk(0, 8'h00, 3'd6, 0, 0, 0, 1, 2'b01, 0));
    tick();
    look("sub_t3", pk(0, 8'h02, 3'd0, 0, 1, 0, 0, 2'b00, 1));
    tick();
    look("sub_back_t0", ZERO);

    // back-to-back add r3,r3 then mv r0,r7 with run high; run toggled mid-instruction
    bus.run = 1'b1; bus.din = 16'h009B;
    look("add_t0", pk(1, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0));
    tick();
    bus.din = 16'h01FF;
    look("add_t1", pk(0, 8'h00, 3'd3, 0, 0, 1, 0, 2'b00, 0));
    tick();
    bus.run = 1'b0;
    look("add_t2", pk(0, 8'h00, 3'd3, 0, 0, 0, 1, 2'b00, 0));
    tick();
    bus.run = 1'b1;
    look("add_t3", pk(0, 8'h08, 3'd0, 0, 1, 0, 0, 2'b00, 1));
    tick();
    bus.din = 16'h0007;
    look("b2b_fetch", pk(1, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0));
    tick();
    bus.run = 1'b0;
    look("b2b_mv_t1", pk(0, 8'h01, 3'd7, 0, 0, 0, 0, 2'b00, 1));
    tick();

    // or r4, r1 -> alu_op 11 in T2
    bus.run = 1'b1; bus.din = 16'h0161;
    tick();
    bus.run = 1'b0;
    tick();
    look("or_t2", pk(0, 8'h00, 3'd1, 0, 0, 0, 1, 2'b11, 0));
    tick();
    look("or_t3", pk(0, 8'h10, 3'd0, 0, 1, 0, 0, 2'b00, 1));
    tick();

    // nop opcodes 111 and 110
    bus.run = 1'b1; bus.din = 16'h01EB;
    tick();
    bus.run = 1'b0;
    look("nop7_t1", pk(0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1));
    tick();
    bus.run = 1'b1; bus.din = 16'h01AD;
    tick();
    bus.run = 1'b0;
    look("nop6_t1", pk(0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1));
    tick();
    look("nop_back_t0", ZERO);

    // reset mid-instruction: and r2, r5 aborted in T2
    bus.run = 1'b1; bus.din = 16'h0115;
    tick();
    bus.run = 1'b0;
    tick();
    look("and_t2", pk(0, 8'h00, 3'd5, 0, 0, 0, 1, 2'b10, 0));
    rst = 1'b1;
    look("abort_now", ZERO);
    tick();
    look("abort_hold", ZERO);
    rst = 1'b0;
    tick();
    look("abort_t0", ZERO);
    tick();
    look("abort_still_t0", ZERO);
    bus.run = 1'b1; bus.din = 16'h0078;
    look("post_rst_t0", pk(1, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0));
    tick();
    bus.run = 1'b0; bus.din = 16'h00AA;
    look("post_rst_mvi", pk(0, 8'h80, 0, 1, 0, 0, 0, 2'b00, 1));
    tick();
    look("final_t0", ZERO);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
